pump_controller: RTL
====================

Name: pump_controller

Overview:
Sequences the refill pump from the two debounced float-switch levels (low and high sensor, 1 = water absent/"empty").
- Starts the pump when the low sensor reads empty and stops it when the high sensor reads wet.
- Enforces a minimum pump-off time (anti-short-cycle) and a maximum fill time.
- Latches a fault on fill timeout or on an impossible sensor combination.
- Sits between the two level debouncers and the pump driver output pin.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz
FILL_TIMEOUT_MS, 30_000, maximum continuous pump-on time in ms; FILL_LIMIT = (CLK_FREQ/1000)*FILL_TIMEOUT_MS cycles, must be ≥ 1
MIN_OFF_MS, 5_000, minimum pump-off time after any pump stop or fault clear in ms; OFF_LIMIT = (CLK_FREQ/1000)*MIN_OFF_MS cycles, must be ≥ 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  level-sensitive run enable
low_empty  input  1  debounced low sensor, 1 = water below low mark
high_empty  input  1  debounced high sensor, 1 = water below high mark
fault_clear  input  1  single-cycle request to leave FAULT
pump_on  output  1  pump drive, registered
fault  output  1  fault flag, registered
fault_code  output  2  0 none, 1 fill timeout, 2 sensor conflict, 3 unused
state  output  3  current state: IDLE=0, MONITOR=1, FILLING=2, COOLDOWN=3, FAULT=4
fill_count  output  8  completed fills (FILLING→COOLDOWN on high_empty=0), saturates at 255

Behaviour:
- One clock, all state in clk domain; reset synchronous active-high, sampled on posedge clk.
- Reset values: state=IDLE, pump_on=0, fault=0, fault_code=0, fill_count=0, timer=0. Reset mid-fill drops pump_on at the same edge.
- Outputs are registered and updated on the same edge as state:
  - pump_on = 1 iff state==FILLING.
  - fault = 1 iff state==FAULT.
- conflict = low_empty & ~high_empty (high wet while low dry).
- Single timer, width $clog2(max(FILL_LIMIT,OFF_LIMIT)+1). Cleared to 0 on every state entry and incremented once per cycle spent in FILLING or COOLDOWN.
- IDLE:
  - enable=1 → MONITOR.
  - Conflict is ignored in IDLE.
- MONITOR, evaluated in priority order:
  1. enable=0 → IDLE.
  2. conflict → FAULT, code 2.
  3. low_empty=1 → FILLING.
- FILLING, evaluated in priority order:
  1. conflict → FAULT, code 2.
  2. high_empty=0 → COOLDOWN, fill_count+1 (saturating).
  3. timer==FILL_LIMIT-1 → FAULT, code 1.
  4. enable=0 → COOLDOWN, no count.
  5. Otherwise timer+1.
  - Without an earlier exit, pump_on stays high for exactly FILL_LIMIT cycles.
  - If full and timeout occur in the same cycle, full wins.
- COOLDOWN, evaluated in priority order:
  1. conflict → FAULT, code 2.
  2. timer==OFF_LIMIT-1 → MONITOR if enable=1, else IDLE.
  3. Otherwise timer+1.
  - COOLDOWN lasts exactly OFF_LIMIT cycles; enable changes do not shorten it.
- FAULT:
  - pump off; fault_code held.
  - fault_clear=1 and conflict=0 → COOLDOWN, fault_code=0.
  - fault_clear while conflict=1 is ignored.
  - enable has no effect in FAULT.
- fault_clear outside FAULT is ignored.
- Pump can never restart sooner than OFF_LIMIT cycles after any stop.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use CLK_FREQ=1000, FILL_TIMEOUT_MS=8, MIN_OFF_MS=4 (FILL_LIMIT=8, OFF_LIMIT=4).
1. Reset with enable=1 and low_empty=high_empty=1 → state 0,1,2 on the first three edges after reset release. Then drop high_empty=0 after 3 pump cycles → pump_on high for exactly 3 cycles, COOLDOWN for 4 cycles, then MONITOR, fill_count=1.
2. Hold high_empty=1 throughout FILLING → pump_on high for exactly 8 cycles, then FAULT with fault=1 and fault_code=1. Pulse fault_clear → COOLDOWN for 4 cycles, fault_code=0.
3. Drive low_empty=1, high_empty=0 in MONITOR → FAULT with code 2 next edge. fault_clear while the conflict persists → stays FAULT. Remove conflict and pulse fault_clear → COOLDOWN.
4. On FILLING timer==7, drive high_empty=0 → COOLDOWN (not FAULT), fill_count increments.
5. Drop enable mid-fill → pump_on drops next edge. Re-raise enable during COOLDOWN → still 4 off cycles, then MONITOR, then FILLING if low_empty=1.
6. Assert reset while FILLING → pump_on=0, state=IDLE, fill_count=0 after that edge. Force 256 completed fills → fill_count saturates at 255.

Source files
------------

// File: rtl/pump_controller.sv
// Refill pump sequencer: starts on low-empty, stops on high-wet, enforces
// minimum off time and maximum fill time, and latches timeout/sensor faults.
module pump_controller #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned FILL_TIMEOUT_MS = 30_000,
  parameter int unsigned MIN_OFF_MS      = 5_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       low_empty,
  input  logic       high_empty,
  input  logic       fault_clear,
  output logic       pump_on,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state,
  output logic [7:0] fill_count
);

  localparam int unsigned FILL_LIMIT = (CLK_FREQ / 1000) * FILL_TIMEOUT_MS;
  localparam int unsigned OFF_LIMIT  = (CLK_FREQ / 1000) * MIN_OFF_MS;
  localparam int unsigned MAX_LIMIT  = (FILL_LIMIT > OFF_LIMIT) ? FILL_LIMIT : OFF_LIMIT;
  localparam int unsigned TW         = $clog2(MAX_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MONITOR  = 3'd1,
    FILLING  = 3'd2,
    COOLDOWN = 3'd3,
    FAULT    = 3'd4
  } state_e;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
  localparam logic [1:0] CODE_CONFLICT = 2'd2;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic [7:0]    fill_count_q, fill_count_d;
  logic          pump_on_q, fault_q;
  logic          conflict;

  assign conflict = low_empty & ~high_empty;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fault_code_d = fault_code_q;
    fill_count_d = fill_count_q;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = MONITOR;
      end
      MONITOR: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (conflict) begin
          state_d      = FAULT;
          fault_code_d = CODE_CONFLICT;
        end else if (low_empty) begin
          state_d = FILLING;
        end
      end
      FILLING: begin
        if (conflict) begin
          state_d      = FAULT;
          fault_code_d = CODE_CONFLICT;
        end else if (!high_empty) begin
          state_d = COOLDOWN;
          if (fill_count_q != 8'hFF) fill_count_d = fill_count_q + 8'd1;
        end else if (timer_q == TW'(FILL_LIMIT - 1)) begin
          state_d      = FAULT;
          fault_code_d = CODE_TIMEOUT;
        end else if (!enable) begin
          state_d = COOLDOWN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COOLDOWN: begin
        if (conflict) begin
          state_d      = FAULT;
          fault_code_d = CODE_CONFLICT;
        end else if (timer_q == TW'(OFF_LIMIT - 1)) begin
          state_d = enable ? MONITOR : IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FAULT: begin
        if (fault_clear && !conflict) begin
          state_d      = COOLDOWN;
          fault_code_d = CODE_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every transition restarts the shared timer in the new state.
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      fault_code_q <= CODE_NONE;
      fill_count_q <= '0;
      pump_on_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fault_code_q <= fault_code_d;
      fill_count_q <= fill_count_d;
      pump_on_q    <= (state_d == FILLING);
      fault_q      <= (state_d == FAULT);
    end
  end

  assign pump_on    = pump_on_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign state      = state_q;
  assign fill_count = fill_count_q;

endmodule
